weight_loader: RTL

- Runtime writer for the per-neuron weight memories used in the non-pretrained build.
- Accepts a byte/word stream over a valid/ready handshake, with the host or UART side as source.
- Writes each incoming word into the correct neuron's weight memory: one-hot write enable, shared address and data buses.
- Sits between the host-link receiver and the bank of weight memories of one layer; the counterpart to the inference-side readers of those memories.

---
 rtl/weight_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// weight_loader: streams host words into per-neuron weight memories (optional checksum: WEIGHT_LOADER_CHECKSUM_EN)
module weight_loader #(
  parameter int numNeurons = 16,
  parameter int numWeights = 16,
  parameter int addressWidth = 4,
  parameter int dataWidth = 8,
  localparam int neuronWidth = (numNeurons > 1) ? $clog2(numNeurons) : 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    inValid,
  input  logic [dataWidth-1:0]    inData,
  output logic                    inReady,
  output logic [numNeurons-1:0]   writeEn,
  output logic [addressWidth-1:0] addr,
  output logic [dataWidth-1:0]    dataOut,
  output logic [neuronWidth-1:0]  neuronIdx,
  output logic                    busy,
  output logic                    done,
  output logic                    checksumErr
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  state_t r_state, w_next;
  logic [addressWidth-1:0] r_w, r_addr;
  logic [neuronWidth-1:0] r_n;
  logic [numNeurons-1:0] r_wen;
  logic [dataWidth-1:0] r_data;
  logic w_xfer, w_load_xfer, w_last, w_wrap, w_start, w_abort;
  assign inReady = (r_state == LOAD || r_state == CHECK) && !abort;
  assign w_xfer = inValid && inReady;
  assign w_load_xfer = w_xfer && r_state == LOAD;
  assign w_wrap = r_w == addressWidth'(numWeights - 1);
  assign w_last = w_wrap && r_n == neuronWidth'(numNeurons - 1);
  assign w_start = r_state == IDLE && start;
  assign w_abort = r_state != IDLE && abort;
  assign writeEn = r_wen;
  assign addr = r_addr;
  assign dataOut = r_data;
  assign neuronIdx = r_n;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE && !abort;
  // next-state selection; abort always wins over a pending transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = start ? LOAD : IDLE;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      LOAD:  w_next = abort ? IDLE : (w_load_xfer && w_last) ? CHECK : LOAD;
`else
      LOAD:  w_next = abort ? IDLE : (w_load_xfer && w_last) ? DONE : LOAD;
`endif
      CHECK: w_next = abort ? IDLE : w_xfer ? DONE : CHECK;
      default: w_next = IDLE;
    endcase
  end
  // state, registered write port and weight/neuron counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_wen <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_w <= '0;
      r_n <= '0;
    end else begin
      r_state <= w_next;
      r_wen <= w_load_xfer ? numNeurons'(1) << r_n : '0;
      if (w_load_xfer) begin
        r_addr <= r_w;
        r_data <= inData;
      end
      if (w_start || w_abort) begin
        r_w <= '0;
        r_n <= '0;
      end else if (w_load_xfer && !w_last) begin
        r_w <= w_wrap ? '0 : r_w + 1'b1;
        r_n <= w_wrap ? r_n + 1'b1 : r_n;
      end
    end
  end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [dataWidth-1:0] r_acc;
  logic r_cerr, w_chk_xfer;
  assign w_chk_xfer = w_xfer && r_state == CHECK;
  assign checksumErr = r_cerr;
  // running sum of accepted weights, compared against the trailing checksum word
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc <= '0;
      r_cerr <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_cerr <= 1'b0;
    end else if (w_abort) begin
      r_acc <= '0;
    end else if (w_load_xfer) begin
      r_acc <= r_acc + inData;
    end else if (w_chk_xfer && inData != r_acc) begin
      r_cerr <= 1'b1;
    end
  end
`else
  assign checksumErr = 1'b0;
`endif
endmodule
